bus_dma_master: RTL and testbench

//  Single-channel block-copy engine acting as the sole master on the shared 64-bit system bus.
//  On start it raises m_req and waits for m_grant. It then copies LEN words from src to dst, one word per read/write pair.
//  Its m_* outputs drive the bus master port directly; m_din returns read data from the selected slave.

---
 rtl/bus_dma_master_pkg.sv | 28 ++
 rtl/bus_dma_master_if.sv | 28 ++
 rtl/bus_dma_master_addr_counter.sv | 46 ++++
 rtl/bus_dma_master.sv | 185 ++++++++++++++++++
 tb/tb_bus_dma_master.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/bus_dma_master_pkg.sv
// Shared definitions for the block-copy DMA master.
// Contents: bus geometry (ADDR_W, DATA_W, LEN_W), sized constants, the bus
// direction encoding and the FSM state encoding.
package bus_dma_master_pkg;

  localparam int ADDR_W = 16;  // bus address width
  localparam int DATA_W = 64;  // bus data width
  localparam int LEN_W  = 8;   // transfer length counter width

  localparam logic BUS_RD = 1'b0;
  localparam logic BUS_WR = 1'b1;

  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_RD_ADDR = 3'd2,
    ST_RD_DATA = 3'd3,
    ST_WR      = 3'd4,
    ST_DONE    = 3'd5
  } dma_state_e;

endpackage

// File: rtl/bus_dma_master_if.sv
// System bus master port bundle.
//   m_req   master -> arbiter  bus request
//   m_wr    master -> slave    1 = write, 0 = read
//   m_addr  master -> slave    word address
//   m_dout  master -> slave    write data
//   m_grant arbiter -> master  bus grant
//   m_din   slave  -> master   read data, valid the cycle after a read address
interface bus_dma_master_if;
  import bus_dma_master_pkg::*;

  logic              m_req;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_dout;
  logic              m_grant;
  logic [DATA_W-1:0] m_din;

  modport master (
    output m_req, m_wr, m_addr, m_dout,
    input  m_grant, m_din
  );

  modport slave (
    input  m_req, m_wr, m_addr, m_dout,
    output m_grant, m_din
  );

endinterface

// File: rtl/bus_dma_master_addr_counter.sv
// Loadable word-address incrementer used for the source and destination
// pointers. Wraps modulo 2^ADDR_W.
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   load_i          load load_val_i (has priority over en_i)
//   en_i            advance by one word
//   load_val_i      value to load
//   cnt_nxt_o       value the pointer holds after the coming edge; lets the
//                   owner register a bus address that lines up with the pointer
module bus_dma_master_addr_counter
  import bus_dma_master_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              en_i,
  input  logic [ADDR_W-1:0] load_val_i,
  output logic [ADDR_W-1:0] cnt_nxt_o
);

  logic [ADDR_W-1:0] cnt_q;
  logic [ADDR_W-1:0] cnt_d;

  // Next pointer value: load, increment with natural wrap, or hold
  always_comb begin
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i) begin
      cnt_d = cnt_q + ADDR_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Pointer register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q <= ADDR_ZERO;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_nxt_o = cnt_d;

endmodule

// File: rtl/bus_dma_master.sv
// Single-channel block-copy engine, sole master on the 64-bit system bus.
// On start it requests the bus, waits for grant, then copies length words from
// src_addr to dst_addr as read-address / read-capture / write triplets.
// Ports:
//   clk_i, reset_i  clock and synchronous active-high reset
//   start_i         1-cycle start pulse, honoured only when idle
//   src_addr_i      first source word address
//   dst_addr_i      first destination word address
//   length_i        number of words to copy (0 completes immediately)
//   bus             master side of the system bus
//   busy_o          transfer in progress
//   done_o          1-cycle completion pulse
// All outputs are registers loaded from the next state, so they describe the
// state the FSM is in during the same cycle.
module bus_dma_master
  import bus_dma_master_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] src_addr_i,
  input  logic [ADDR_W-1:0] dst_addr_i,
  input  logic [LEN_W-1:0]  length_i,
  bus_dma_master_if.master  bus,
  output logic              busy_o,
  output logic              done_o
);

  dma_state_e        state_q, state_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic              load_s;
  logic              adv_s;
  logic [ADDR_W-1:0] src_nxt_s;
  logic [ADDR_W-1:0] dst_nxt_s;

  logic              m_req_q, m_req_d;
  logic              m_wr_q, m_wr_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_dout_q, m_dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  assign load_s = (state_q == ST_IDLE) && start_i;
  // A word only completes when its write cycle is granted.
  assign adv_s  = (state_q == ST_WR) && bus.m_grant;

  bus_dma_master_addr_counter u_src_ptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load_s),
    .en_i       (adv_s),
    .load_val_i (src_addr_i),
    .cnt_nxt_o  (src_nxt_s)
  );

  bus_dma_master_addr_counter u_dst_ptr (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (load_s),
    .en_i       (adv_s),
    .load_val_i (dst_addr_i),
    .cnt_nxt_o  (dst_nxt_s)
  );

  // Words still to copy
  always_comb begin
    if (load_s) begin
      remaining_d = length_i;
    end else if (adv_s) begin
      remaining_d = remaining_q - LEN_ONE;
    end else begin
      remaining_d = remaining_q;
    end
  end

  // State, counter and output registers
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      remaining_q <= LEN_ZERO;
      m_req_q     <= 1'b0;
      m_wr_q      <= BUS_RD;
      m_addr_q    <= ADDR_ZERO;
      m_dout_q    <= DATA_ZERO;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      m_req_q     <= m_req_d;
      m_wr_q      <= m_wr_d;
      m_addr_q    <= m_addr_d;
      m_dout_q    <= m_dout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic; without grant the bus phases stall, and an ungranted
  // capture cycle replays the read address
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          state_d = (length_i == LEN_ZERO) ? ST_DONE : ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_REQ: begin
        state_d = bus.m_grant ? ST_RD_ADDR : ST_REQ;
      end
      ST_RD_ADDR: begin
        state_d = bus.m_grant ? ST_RD_DATA : ST_RD_ADDR;
      end
      ST_RD_DATA: begin
        state_d = bus.m_grant ? ST_WR : ST_RD_ADDR;
      end
      ST_WR: begin
        if (bus.m_grant) begin
          state_d = (remaining_q == LEN_ONE) ? ST_DONE : ST_RD_ADDR;
        end else begin
          state_d = ST_WR;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Output values for the state being entered. m_dout doubles as the data
  // register: it takes m_din on the granted capture cycle and holds otherwise.
  always_comb begin
    m_req_d  = 1'b0;
    m_wr_d   = BUS_RD;
    m_addr_d = m_addr_q;
    m_dout_d = m_dout_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_d)
      ST_IDLE: begin
        m_req_d = 1'b0;
      end
      ST_REQ: begin
        m_req_d = 1'b1;
        busy_d  = 1'b1;
      end
      ST_RD_ADDR, ST_RD_DATA: begin
        m_req_d  = 1'b1;
        busy_d   = 1'b1;
        m_addr_d = src_nxt_s;
      end
      ST_WR: begin
        m_req_d  = 1'b1;
        busy_d   = 1'b1;
        m_wr_d   = BUS_WR;
        m_addr_d = dst_nxt_s;
        if (state_q == ST_RD_DATA) begin
          m_dout_d = bus.m_din;
        end else begin
          m_dout_d = m_dout_q;
        end
      end
      ST_DONE: begin
        done_d = 1'b1;
      end
      default: begin
        m_req_d = 1'b0;
      end
    endcase
  end

  assign bus.m_req  = m_req_q;
  assign bus.m_wr   = m_wr_q;
  assign bus.m_addr = m_addr_q;
  assign bus.m_dout = m_dout_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;

endmodule

// File: tb/tb_bus_dma_master.sv
// Self-checking bench for bus_dma_master: directed cases plus randomized
// transfers checked against a copy-list model of the expected bus writes.
module tb_bus_dma_master;
  import bus_dma_master_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [15:0] src_addr_i;
  logic [15:0] dst_addr_i;
  logic [7:0]  length_i;
  logic        busy_o;
  logic        done_o;

  bus_dma_master_if bus ();

  bus_dma_master dut (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .start_i    (start_i),
    .src_addr_i (src_addr_i),
    .dst_addr_i (dst_addr_i),
    .length_i   (length_i),
    .bus        (bus),
    .busy_o     (busy_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Source memory contents are a fixed function of the address.
  logic [63:0] salt;
  function automatic logic [63:0] mem_f(input logic [15:0] a);
    return {a, ~a, a ^ 16'h5A5A, a + 16'h1234} ^ salt;
  endfunction

  // Slave: read data appears the cycle after the address.
  always @(posedge clk_i) bus.m_din <= mem_f(bus.m_addr);

  // Bus monitor
  logic [15:0] wa_q[$];
  logic [63:0] wd_q[$];
  int done_count = 0, done_cyc = 0, viol = 0, req_cycles = 0, busy_cycles = 0;
  logic req_at_done = 1'b0, busy_at_done = 1'b0;
  always @(negedge clk_i) begin
    if (bus.m_req && bus.m_wr && bus.m_grant) begin
      wa_q.push_back(bus.m_addr);
      wd_q.push_back(bus.m_dout);
    end
    if (done_o) begin
      done_count   <= done_count + 1;
      done_cyc     <= cyc;
      req_at_done  <= bus.m_req;
      busy_at_done <= busy_o;
    end
    if (bus.m_wr && !bus.m_req) viol <= viol + 1;
    if (bus.m_req) req_cycles <= req_cycles + 1;
    if (busy_o) busy_cycles <= busy_cycles + 1;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One transfer; drop_word (1-based) selects the write whose grant is removed
  // for drop_len cycles, extra_start pulses start mid-transfer.
  task automatic run_xfer(input logic [15:0] src, input logic [15:0] dst, input int len,
                          input int drop_word, input int drop_len, input bit extra_start);
    int d0, rq0, bz0, g, nw;
    bit dropped;
    logic [15:0] drop_addr, ea;
    d0 = done_count;
    rq0 = req_cycles;
    bz0 = busy_cycles;
    wa_q.delete();
    wd_q.delete();
    @(posedge clk_i); #1;
    src_addr_i = src; dst_addr_i = dst; length_i = 8'(len); start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    if (len == 0) begin
      check("len0_done", 64'(done_o), 64'd1);
      @(posedge clk_i); #1;
      @(posedge clk_i); #1;
      check("len0_req_cycles", 64'(req_cycles - rq0), 64'd0);
      check("len0_busy_cycles", 64'(busy_cycles - bz0), 64'd0);
      check("len0_done_count", 64'(done_count - d0), 64'd1);
      return;
    end
    check("req_after_start", 64'(bus.m_req), 64'd1);
    check("busy_after_start", 64'(busy_o), 64'd1);
    @(posedge clk_i); #1;
    bus.m_grant = 1'b1;
    g = cyc;
    dropped = 1'b0;
    drop_addr = dst + 16'(drop_word - 1);
    for (int k = 0; k < 400 && done_count == d0; k++) begin
      @(posedge clk_i); #1;
      start_i = extra_start && (k == 2);
      if (!dropped && drop_len > 0 && bus.m_wr && bus.m_addr == drop_addr) begin
        dropped = 1'b1;
        bus.m_grant = 1'b0;
        repeat (drop_len) @(posedge clk_i);
        #1;
        bus.m_grant = 1'b1;
      end
    end
    start_i = 1'b0;
    bus.m_grant = 1'b0;
    check("done_seen", 64'(done_count - d0), 64'd1);
    check("done_time", 64'(done_cyc - g), 64'(3 * len + 1 + drop_len));
    check("req_at_done", 64'(req_at_done), 64'd0);
    check("busy_at_done", 64'(busy_at_done), 64'd0);
    nw = wa_q.size();
    check("wr_count", 64'(nw), 64'(len));
    for (int i = 0; i < len && i < nw; i++) begin
      ea = dst + 16'(i);
      check("wr_addr", 64'(wa_q[i]), 64'(ea));
      ea = src + 16'(i);
      check("wr_data", wd_q[i], mem_f(ea));
    end
    if (extra_start) begin
      repeat (10) @(posedge clk_i);
      #1;
      check("extra_start_done_count", 64'(done_count - d0), 64'd1);
      check("extra_start_req", 64'(bus.m_req), 64'd0);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_m_req"}, 64'(bus.m_req), 64'd0);
    check({pfx, "_m_wr"}, 64'(bus.m_wr), 64'd0);
    check({pfx, "_m_addr"}, 64'(bus.m_addr), 64'd0);
    check({pfx, "_m_dout"}, bus.m_dout, 64'd0);
    check({pfx, "_busy"}, 64'(busy_o), 64'd0);
    check({pfx, "_done"}, 64'(done_o), 64'd0);
  endtask

  initial begin
    int d0, len, dw, dl;
    salt = {$urandom, $urandom};
    reset_i = 1'b1; start_i = 1'b0; bus.m_grant = 1'b0;
    src_addr_i = 16'h0000; dst_addr_i = 16'h0000; length_i = 8'd0;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset_outputs("rst");
    reset_i = 1'b0;

    run_xfer(16'h0010, 16'h8010, 4, 0, 0, 1'b0);  // basic copy
    run_xfer(16'h1234, 16'h4321, 0, 0, 0, 1'b0);  // zero length
    run_xfer(16'hFFFF, 16'h7FFF, 2, 0, 0, 1'b0);  // address wrap
    run_xfer(16'h0100, 16'h0200, 3, 2, 5, 1'b0);  // grant loss in write 2
    run_xfer(16'h0300, 16'h0400, 3, 0, 0, 1'b1);  // start while busy

    // Reset during the read-capture cycle
    @(posedge clk_i); #1;
    src_addr_i = 16'h0A00; dst_addr_i = 16'h0B00; length_i = 8'd5; start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    @(posedge clk_i); #1;
    bus.m_grant = 1'b1;
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    check("pre_rst_addr", 64'(bus.m_addr), 64'h0A00);
    d0 = done_count;
    reset_i = 1'b1;
    @(posedge clk_i); #1;
    check_reset_outputs("midrst");
    reset_i = 1'b0;
    bus.m_grant = 1'b0;
    repeat (4) @(posedge clk_i);
    #1;
    check("midrst_no_done", 64'(done_count - d0), 64'd0);
    run_xfer(16'h0C00, 16'h0D00, 2, 0, 0, 1'b0);

    // Randomized transfers
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 10);
      if ($urandom_range(0, 1) == 1) begin
        dw = $urandom_range(1, len);
        dl = $urandom_range(1, 4);
      end else begin
        dw = 0;
        dl = 0;
      end
      run_xfer(16'($urandom), 16'($urandom), len, dw, dl, 1'b0);
    end

    check("wr_without_req", 64'(viol), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
